// File: rtl/gemm_tile_scheduler_if.sv
// Job control, SRAM address and MAC strobe bundle between the GEMM scheduler and its surroundings.
// master = scheduler side (drives addresses/strobes/status), slave = top-level registers, SRAMs and MAC array.
interface gemm_tile_scheduler_if #(
    parameter int AddrWidth     = 12,
    parameter int SizeAddrWidth = 32
);
    logic                     start_i;
    logic [SizeAddrWidth-1:0] M_size_i;
    logic [SizeAddrWidth-1:0] K_size_i;
    logic [SizeAddrWidth-1:0] N_size_i;
    logic [AddrWidth-1:0]     sram_a_addr_o;
    logic [AddrWidth-1:0]     sram_b_addr_o;
    logic [AddrWidth-1:0]     sram_c_addr_o;
    logic                     sram_c_we_o;
    logic                     mac_valid_o;
    logic                     mac_clear_o;
    logic                     busy_o;
    logic                     done_o;
    logic                     err_o;
    logic [31:0]              cycle_count_o;

    modport master (
        input  start_i, M_size_i, K_size_i, N_size_i,
        output sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_we_o,
               mac_valid_o, mac_clear_o, busy_o, done_o, err_o, cycle_count_o
    );

    modport slave (
        output start_i, M_size_i, K_size_i, N_size_i,
        input  sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_we_o,
               mac_valid_o, mac_clear_o, busy_o, done_o, err_o, cycle_count_o
    );
endinterface

// File: rtl/gemm_tile_scheduler.sv
// Output-stationary GEMM tile sequencer; optional busy-cycle counter under GEMM_SCHED_PERF_CNT_EN.
// Each tile takes K+2 cycles (K stream, 1 drain, 1 write); no backpressure, the datapath must keep up.
module gemm_tile_scheduler #(
    parameter int AddrWidth     = 12,
    parameter int SizeAddrWidth = 32,
    parameter int RowPar        = 4,
    parameter int ColPar        = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    gemm_tile_scheduler_if.master bus
);

    localparam int RowShift = $clog2(RowPar);
    localparam int ColShift = $clog2(ColPar);
    localparam logic [SizeAddrWidth-1:0] RowMask = SizeAddrWidth'(RowPar - 1);
    localparam logic [SizeAddrWidth-1:0] ColMask = SizeAddrWidth'(ColPar - 1);

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    state_t                   state_q;

    // Latched job geometry
    logic [SizeAddrWidth-1:0] m_t_q;
    logic [SizeAddrWidth-1:0] n_t_q;
    logic [SizeAddrWidth-1:0] k_size_q;

    // Loop counters
    logic [SizeAddrWidth-1:0] k_q;
    logic [SizeAddrWidth-1:0] tile_m_q;
    logic [SizeAddrWidth-1:0] tile_n_q;

    // Running bases replace multipliers; modulo-2^AddrWidth sums equal the truncated full products
    logic [AddrWidth-1:0]     a_base_q;
    logic [AddrWidth-1:0]     b_base_q;
    logic [AddrWidth-1:0]     c_idx_q;

    // Registered outputs
    logic [AddrWidth-1:0]     a_addr_q;
    logic [AddrWidth-1:0]     b_addr_q;
    logic [AddrWidth-1:0]     c_addr_q;
    logic                     c_we_q;
    logic                     mac_valid_q;
    logic                     mac_clear_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     err_q;

    logic                     job_ok;
    logic [SizeAddrWidth-1:0] k_nxt;
    logic                     k_last;
    logic                     last_n;
    logic                     last_m;
    logic [AddrWidth-1:0]     k_size_trunc;
    logic [AddrWidth-1:0]     a_base_nxt;
    logic [AddrWidth-1:0]     b_base_nxt;

    assign job_ok = (bus.M_size_i != '0) && (bus.K_size_i != '0) && (bus.N_size_i != '0) &&
                    ((bus.M_size_i & RowMask) == '0) && ((bus.N_size_i & ColMask) == '0);

    assign k_nxt        = k_q + 1'b1;
    assign k_last       = (k_nxt == k_size_q);
    assign last_n       = (tile_n_q + 1'b1 == n_t_q);
    assign last_m       = (tile_m_q + 1'b1 == m_t_q);
    assign k_size_trunc = AddrWidth'(k_size_q);

    // Moving to the next tile_m row rewinds B to column-tile 0 and steps A by one K block
    assign a_base_nxt = last_n ? (a_base_q + k_size_trunc) : a_base_q;
    assign b_base_nxt = last_n ? '0 : (b_base_q + k_size_trunc);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            m_t_q       <= '0;
            n_t_q       <= '0;
            k_size_q    <= '0;
            k_q         <= '0;
            tile_m_q    <= '0;
            tile_n_q    <= '0;
            a_base_q    <= '0;
            b_base_q    <= '0;
            c_idx_q     <= '0;
            a_addr_q    <= '0;
            b_addr_q    <= '0;
            c_addr_q    <= '0;
            c_we_q      <= 1'b0;
            mac_valid_q <= 1'b0;
            mac_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        m_t_q    <= bus.M_size_i >> RowShift;
                        n_t_q    <= bus.N_size_i >> ColShift;
                        k_size_q <= bus.K_size_i;
                        if (job_ok) begin
                            state_q  <= STREAM;
                            busy_q   <= 1'b1;
                            err_q    <= 1'b0;
                            k_q      <= '0;
                            tile_m_q <= '0;
                            tile_n_q <= '0;
                            a_base_q <= '0;
                            b_base_q <= '0;
                            c_idx_q  <= '0;
                            a_addr_q <= '0;
                            b_addr_q <= '0;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end

                STREAM: begin
                    // The address presented now returns from SRAM next cycle
                    mac_valid_q <= 1'b1;
                    mac_clear_q <= (k_q == '0);
                    if (k_last) begin
                        state_q <= DRAIN;
                    end else begin
                        k_q      <= k_nxt;
                        a_addr_q <= a_base_q + AddrWidth'(k_nxt);
                        b_addr_q <= b_base_q + AddrWidth'(k_nxt);
                    end
                end

                DRAIN: begin
                    mac_valid_q <= 1'b0;
                    mac_clear_q <= 1'b0;
                    c_we_q      <= 1'b1;
                    c_addr_q    <= c_idx_q;
                    state_q     <= WRITE;
                end

                WRITE: begin
                    c_we_q <= 1'b0;
                    k_q    <= '0;
                    if (last_n && last_m) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= STREAM;
                        tile_n_q <= last_n ? '0 : tile_n_q + 1'b1;
                        tile_m_q <= last_n ? tile_m_q + 1'b1 : tile_m_q;
                        a_base_q <= a_base_nxt;
                        b_base_q <= b_base_nxt;
                        a_addr_q <= a_base_nxt;
                        b_addr_q <= b_base_nxt;
                        c_idx_q  <= c_idx_q + 1'b1;
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.sram_a_addr_o = a_addr_q;
    assign bus.sram_b_addr_o = b_addr_q;
    assign bus.sram_c_addr_o = c_addr_q;
    assign bus.sram_c_we_o   = c_we_q;
    assign bus.mac_valid_o   = mac_valid_q;
    assign bus.mac_clear_o   = mac_clear_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.err_o         = err_q;

`ifdef GEMM_SCHED_PERF_CNT_EN
    logic        start_acc;
    logic [31:0] cyc_q;

    assign start_acc = (state_q == IDLE) && bus.start_i && job_ok;

    // Rejected starts leave the previous job's count visible
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_q <= '0;
        end else if (start_acc) begin
            cyc_q <= '0;
        end else if (busy_q && (cyc_q != '1)) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    assign bus.cycle_count_o = cyc_q;
`else
    assign bus.cycle_count_o = '0;
`endif

endmodule
